// File: rtl/energy_telemetry_uart_tx.sv
// energy_telemetry_uart_tx: buffers 8-bit converter samples in a small FIFO and
// sends them as packets (SYNC, seq, PKT_LEN payload bytes, checksum) on a UART pin.
// Optional build macro TELEM_PARITY_EN switches frames from 8N1 to 8E1.
module energy_telemetry_uart_tx #(
    parameter int          CLKS_PER_BIT = 4,
    parameter int          PKT_LEN      = 2,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [7:0]                    sample_in,
    input  logic                          sample_valid,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(PKT_LEN + 1);
`ifdef TELEM_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(FRAME_BITS - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(PKT_LEN - 1);
    localparam logic [AW:0]   PKT_NEED  = (AW+1)'(PKT_LEN);
    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

    // Full serial frame for one byte, LSB is the first bit on the wire.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] b);
`ifdef TELEM_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_SEQ,
        S_DATA,
        S_CSUM
    } pkt_state_t;

    pkt_state_t state, state_next;

    // Sample FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, push, pop, drop;
    logic [7:0]    head;

    // Byte shifter and packet bookkeeping
    logic [FRAME_BITS-1:0] sh;
    logic [FRAME_BITS-1:0] frame_next;
    logic [CW-1:0]         clk_cnt;
    logic [3:0]            bit_cnt;
    logic [IW-1:0]         data_idx;
    logic [7:0]            seq;
    logic [7:0]            csum;
    logic                  load;
    logic [7:0]            load_byte;
    logic                  byte_done;
    logic                  bit_end;

    assign fifo_count = wr_ptr - rd_ptr;
    assign full       = (fifo_count == FIFO_FULL);
    assign head       = mem[rd_ptr[AW-1:0]];
    // A full FIFO still accepts a sample if an entry leaves in the same cycle.
    assign push       = sample_valid && ena && (!full || pop);
    assign drop       = sample_valid && ena && full && !pop;

    assign bit_end    = (state != S_IDLE) && (clk_cnt == CLK_LAST);
    assign byte_done  = bit_end && (bit_cnt == BIT_LAST);
    assign frame_next = build_frame(load_byte);
    assign busy       = (state != S_IDLE);

    // Sample storage; contents need no reset because pointers gate validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= sample_in;
        end
    end

    // FIFO pointers (one bit wider than the address) and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Packet FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Packet FSM next state: picks the next byte to load at each byte boundary.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_byte  = SYNC_BYTE;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (ena && (fifo_count >= PKT_NEED)) begin
                    state_next = S_SYNC;
                    load       = 1'b1;
                    load_byte  = SYNC_BYTE;
                end
            end
            S_SYNC: begin
                if (byte_done) begin
                    state_next = S_SEQ;
                    load       = 1'b1;
                    load_byte  = seq;
                end
            end
            S_SEQ: begin
                if (byte_done) begin
                    state_next = S_DATA;
                    load       = 1'b1;
                    load_byte  = head;
                    pop        = 1'b1;
                end
            end
            S_DATA: begin
                if (byte_done) begin
                    load = 1'b1;
                    if (data_idx == DATA_LAST) begin
                        state_next = S_CSUM;
                        load_byte  = csum;
                    end else begin
                        load_byte  = head;
                        pop        = 1'b1;
                    end
                end
            end
            S_CSUM: begin
                if (byte_done) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Bit timing, serial output, payload index and sequence number.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx       <= 1'b1;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            data_idx <= '0;
            seq      <= 8'd0;
        end else begin
            if (load) begin
                tx      <= frame_next[0];
                clk_cnt <= '0;
                bit_cnt <= '0;
            end else if (state != S_IDLE) begin
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt <= '0;
                    if (bit_cnt == BIT_LAST) begin
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                    end else begin
                        tx      <= sh[1];
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end else begin
                    clk_cnt <= clk_cnt + CW'(1);
                end
            end else begin
                tx <= 1'b1;
            end

            if ((state == S_SEQ) && byte_done) begin
                data_idx <= '0;
            end else if ((state == S_DATA) && byte_done) begin
                data_idx <= data_idx + IW'(1);
            end

            if ((state == S_CSUM) && byte_done) begin
                seq <= seq + 8'd1;
            end
        end
    end

    // Frame shift register and running checksum (seq plus payload, mod 256).
    always_ff @(posedge clk) begin
        if (load) begin
            sh <= frame_next;
        end else if (bit_end) begin
            sh <= {1'b1, sh[FRAME_BITS-1:1]};
        end
        if ((state == S_SYNC) && byte_done) begin
            csum <= seq;
        end else if (pop) begin
            csum <= csum + head;
        end
    end

endmodule

// File: tb/tb_energy_telemetry_uart_tx.sv
// Bench for energy_telemetry_uart_tx: a sample-level packet model feeds an
// expected-byte queue; a UART receiver process decodes tx and compares.
module tb_energy_telemetry_uart_tx;

    localparam int         CPB  = 4;
    localparam int         PL   = 2;
    localparam int         FD   = 4;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef TELEM_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int PKT_CYC = (PL + 3) * FB * CPB;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [$clog2(FD):0] fifo_count;

    energy_telemetry_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .PKT_LEN      (PL),
        .FIFO_DEPTH   (FD),
        .SYNC_BYTE    (SYNC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] acc[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_seq;
    bit         m_ovf;
    int         bc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Accepted sample: once PL samples are waiting, they form the next packet.
    task automatic model_accept(input logic [7:0] b);
        logic [7:0] sum;
        logic [7:0] x;
        acc.push_back(b);
        if (acc.size() >= PL) begin
            sum = m_seq;
            exp_q.push_back(SYNC);
            exp_q.push_back(m_seq);
            for (int i = 0; i < PL; i++) begin
                x = acc.pop_front();
                exp_q.push_back(x);
                sum = sum + x;
            end
            exp_q.push_back(sum);
            m_seq = m_seq + 8'd1;
        end
    endtask

    // Called at a negedge; drives a one-cycle strobe, returns at the next negedge.
    task automatic push_sample(input logic [7:0] b, input bit will_drop);
        sample_in    = b;
        sample_valid = 1'b1;
        if (ena && !will_drop) model_accept(b);
        else if (ena && will_drop) m_ovf = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle: timeout after %0d cycles, %0d bytes pending", n, exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic mon_wait(input int n, output bit ok);
        ok = 1'b1;
        repeat (n) begin
            @(negedge clk);
            if (!rst_n) ok = 1'b0;
        end
    endtask

    task automatic rx_byte();
        logic [7:0] d;
        bit ok;
        d = 8'h00;
        mon_wait(CPB / 2, ok);
        if (!ok) return;
        check("start_bit", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            mon_wait(CPB, ok);
            if (!ok) return;
            d[i] = tx;
        end
`ifdef TELEM_PARITY_EN
        mon_wait(CPB, ok);
        if (!ok) return;
        check("parity_bit", {31'd0, tx}, {31'd0, ^d});
`endif
        mon_wait(CPB, ok);
        if (!ok) return;
        check("stop_bit", {31'd0, tx}, 32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_byte: got unexpected byte %0h expected none", d);
        end else begin
            check("rx_byte", {24'd0, d}, {24'd0, exp_q.pop_front()});
        end
    endtask

    // UART receiver: decode every frame seen on tx and score it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) rx_byte();
        end
    end

    // Busy-width monitor: every completed packet holds busy for PKT_CYC cycles.
    initial begin
        bc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) bc = 0;
            else if (busy) bc++;
            else if (bc != 0) begin
                check("busy_cycles", bc, PKT_CYC);
                bc = 0;
            end
        end
    end

    initial begin
        int bad;
        int gap;
        int k;
        rst_n        = 1'b1;
        ena          = 1'b0;
        sample_valid = 1'b0;
        sample_in    = 8'h00;
        m_seq        = 8'd0;
        m_ovf        = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        check("reset_fifo_count", {29'd0, fifo_count}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle_tx_high", bad, 0);

        // Basic packet and seq/checksum wrap of the sum
        push_sample(8'h11, 1'b0);
        push_sample(8'h22, 1'b0);
        wait_idle(600);
        check("basic_fifo_empty", {29'd0, fifo_count}, 32'd0);
        push_sample(8'hFF, 1'b0);
        push_sample(8'h02, 1'b0);
        wait_idle(600);
        check("wrap_fifo_empty", {29'd0, fifo_count}, 32'd0);

        // Enable gating: samples ignored, no packet starts
        ena = 1'b0;
        push_sample(8'hAA, 1'b0);
        push_sample(8'hBB, 1'b0);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("gated_tx_idle", bad, 0);
        check("gated_fifo_count", {29'd0, fifo_count}, 32'd0);
        check("gated_overflow", {31'd0, overflow}, 32'd0);
        ena = 1'b1;

        // ena drops mid-packet: packet still completes
        push_sample(8'h33, 1'b0);
        push_sample(8'h44, 1'b0);
        repeat (20) @(negedge clk);
        check("mid_ena_busy", {31'd0, busy}, 32'd1);
        ena = 1'b0;
        wait_idle(600);
        check("mid_ena_fifo_empty", {29'd0, fifo_count}, 32'd0);
        ena = 1'b1;

        // Overflow: five back-to-back samples into a four-entry FIFO
        push_sample(8'h01, 1'b0);
        push_sample(8'h02, 1'b0);
        push_sample(8'h03, 1'b0);
        push_sample(8'h04, 1'b0);
        push_sample(8'h05, 1'b1);
        check("ovf_flag", {31'd0, overflow}, {31'd0, m_ovf});
        check("ovf_fifo_full", {29'd0, fifo_count}, FD);
        wait_idle(1200);
        check("ovf_fifo_empty", {29'd0, fifo_count}, 32'd0);

        // Randomized packets, long enough to wrap seq past 255
        for (int p = 0; p < 258; p++) begin
            push_sample(8'($urandom), 1'b0);
            k = $urandom_range(0, 3);
            repeat (k) @(negedge clk);
            push_sample(8'($urandom), 1'b0);
            gap = 205 + $urandom_range(0, 7);
            for (int c = 0; c < gap; c++) begin
                @(negedge clk);
                if (p % 16 == 7) ena = !(c >= 30 && c < 46);
                if (p % 16 == 11) begin
                    if (c == 60) begin
                        ena          = 1'b0;
                        sample_in    = 8'($urandom);
                        sample_valid = 1'b1;
                    end else if (c == 61) begin
                        sample_valid = 1'b0;
                        ena          = 1'b1;
                    end
                end
            end
            ena = 1'b1;
        end
        wait_idle(1200);
        check("rand_fifo_count", {29'd0, fifo_count}, acc.size());
        check("rand_overflow_sticky", {31'd0, overflow}, {31'd0, m_ovf});
        check("rand_seq_wrapped", {24'd0, m_seq}, 32'd2 + 32'd3 + 32'd258 - 32'd256);

        // Reset during a payload data bit
        push_sample(8'h5A, 1'b0);
        push_sample(8'hC3, 1'b0);
        k = 0;
        while (!busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        repeat (2 * FB * CPB + 10) @(negedge clk);
        #3 rst_n = 1'b0;
        acc.delete();
        exp_q.delete();
        m_seq = 8'd0;
        m_ovf = 1'b0;
        #1;
        check("midreset_tx", {31'd0, tx}, 32'd1);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_overflow", {31'd0, overflow}, 32'd0);
        check("midreset_fifo_count", {29'd0, fifo_count}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("post_reset_quiet", bad, 0);

        // Fresh packet after reset restarts at seq 0; 0x11/0x07 exercise parity 0/1
        push_sample(8'h11, 1'b0);
        push_sample(8'h07, 1'b0);
        wait_idle(600);
        check("final_fifo_empty", {29'd0, fifo_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/energy_telemetry_uart_tx.md
Name: energy_telemetry_uart_tx

Overview:
Downstream telemetry stage for tt_um_vedm_industries. It consumes the 8-bit converter/data sample stream (the gated uo_out byte plus a valid strobe) and buffers samples in a small FIFO. It frames them into packets and serialises them over a single UART TX pin (8N1) for off-chip logging of converter data.

Parameters:
CLKS_PER_BIT, 4, clock cycles per UART bit (>=2)
PKT_LEN, 2, payload samples per packet (1..FIFO_DEPTH)
FIFO_DEPTH, 4, sample FIFO entries, power of 2 (>=2)
SYNC_BYTE, 8'hA5, first byte of every packet

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  enable; gates sample capture and packet start
sample_in  input  8  sample byte from converter output stage
sample_valid  input  1  sample_in valid this cycle (single-cycle strobe)
tx  output  1  UART serial out, idle high
busy  output  1  high while a packet is being transmitted
overflow  output  1  sticky: a valid sample was dropped because the FIFO was full
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): tx=1, busy=0, overflow=0, fifo_count=0. FIFO is emptied, seq=0, both FSMs return to IDLE. Reset mid-byte forces tx high immediately.
- Push condition: sample_valid && ena && (!full || pop same cycle). A push with ena=0 is ignored silently.
- Sample drop: sample_valid && ena && full && !pop drops the sample and sets overflow=1 on the next edge. overflow stays set until reset.
- Packet FSM states: IDLE -> SYNC -> SEQ -> DATA(xPKT_LEN) -> CSUM -> IDLE.
- IDLE -> SYNC occurs when ena=1 && fifo_count>=PKT_LEN. busy rises on that edge and tx goes low (start bit) on the same edge.
- Packet bytes are sent in order: SYNC_BYTE, seq, PKT_LEN payload bytes (FIFO order), checksum.
- FIFO pop happens in the cycle a payload byte is loaded into the shifter.
- checksum = (seq + sum of payload bytes) mod 256.
- seq increments after CSUM completes and wraps 255->0.
- ena falling mid-packet: the current packet completes. No new packet starts while ena=0.
- Byte shifter frame: start bit (0), 8 data bits LSB-first, stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles.
- Bytes within a packet are back-to-back: the next start bit immediately follows the previous stop bit, with no idle gap.
- busy falls on the edge that ends the CSUM stop bit. If fifo_count>=PKT_LEN at that point, the next packet starts one cycle later after one idle-high cycle.
- Packet duration: (PKT_LEN+3)*10*CLKS_PER_BIT cycles.
- Arithmetic: all byte sums are 8-bit modulo. fifo_count uses wrap-safe pointers one bit wider than the address.

Optional Feature:
TELEM_PARITY_EN: when defined, frames are 8E1. An even-parity bit (XOR of the 8 data bits) is inserted between bit 7 and the stop bit. This gives 11 bits per byte and a packet length of (PKT_LEN+3)*11*CLKS_PER_BIT cycles. When undefined, frames are 8N1 as above and no parity logic is synthesised.

Test Plan:
- Reset: rst_n=0 -> tx=1, busy=0, overflow=0, fifo_count=0. Hold ena=1 with no samples for 100 cycles -> tx stays 1.
- Basic packet (CLKS_PER_BIT=4, PKT_LEN=2): push 0x11, 0x22 with ena=1 -> decoded bytes A5,00,11,22,33. busy is high for exactly 200 cycles and fifo_count returns to 0.
- Seq/checksum wrap: a second packet with 0xFF, 0x02 -> bytes A5,01,FF,02,02. After 256 packets, seq reads 00 again.
- Enable gating: ena=0, push 0xAA, 0xBB -> fifo_count stays 0, tx stays 1, overflow=0. Drop ena mid-packet -> that packet still completes intact.
- Overflow: push 5 samples on consecutive cycles (FIFO_DEPTH=4) -> 5th dropped, overflow=1. First packet carries samples 1-2, second carries 3-4.
- Reset mid-transmission: assert rst_n=0 during a data bit -> tx=1 and busy=0 immediately. After release, no partial packet resumes. With TELEM_PARITY_EN, byte 0x11 carries parity bit 0 and byte 0x07 carries parity bit 1.
